rr_sel_arb4: RTL and testbench

RR_SEL_ARB4 -- requirements
Module: rr_sel_arb4

---
 rtl/rr_sel_arb4_pkg.sv | 20 ++
 rtl/rr_sel_arb4_pick.sv | 24 ++
 rtl/rr_sel_arb4.sv | 104 ++++++++++
 tb/tb_rr_sel_arb4.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rr_sel_arb4_pkg.sv
// Shared types and constants for the 4-channel round-robin mux-select arbiter.
// The FSM state enum, channel count and select width live here.
package rr_sel_arb4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_sel_arb4_pick.sv
// Round-robin picker: first set request scanning upward from ptr, modulo 4.
// Purely combinational; the arbiter registers the result on entry to GRANT.
module rr_pick4
  import rr_sel_arb4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    pick = '0;
    idx  = '0;
    any  = |req;
    // Walk from farthest to nearest so the channel closest to ptr wins last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/rr_sel_arb4.sv
// Two-state round-robin arbiter driving a 4:1 mux select, with a bounded hold
// time per grant and a mandatory idle cycle between grants.
module rr_sel_arb4
  import rr_sel_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_sel_arb4: MAX_HOLD out of range 2..255");
  end

  state_e            state_q;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [NUM_CH-1:0] gnt_q;
  logic              gnt_valid_q;
  logic              timeout_q;

  logic [SEL_W-1:0]  pick;
  logic              pick_any;
  logic              owner_req, rel_max, release_w, timeout_w;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  // sel_q doubles as the owner index while in GRANT.
  assign owner_req = req[sel_q];
  assign rel_max   = (hold_q == HOLD_LAST);
  assign release_w = done | ~owner_req | rel_max;
  assign timeout_w = rel_max & ~done & owner_req;
  assign ptr_d     = sel_q + SEL_W'(1);
  assign hold_d    = hold_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          hold_q    <= '0;
          if (pick_any) begin
            state_q     <= GRANT;
            sel_q       <= pick;
            gnt_q       <= onehot(pick);
            gnt_valid_q <= 1'b1;
          end else begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (release_w) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            hold_q      <= '0;
            timeout_q   <= timeout_w;
          end else begin
            hold_q    <= hold_d;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
          timeout_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel_arb4.sv
// Directed and randomized bench for rr_sel_arb4 against a behavioural
// round-robin model, with MAX_HOLD = 4 so hold-time releases occur often.
module tb_rr_sel_arb4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_busy;
  int m_owner, m_cnt, m_ptr, m_sel;
  bit m_to;

  int order_q[$];
  int hits;

  rr_sel_arb4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic int rr_choose(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit stop_done, stop_req, stop_max;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_sel = 0; m_to = 0; m_owner = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (req != 4'b0000) begin
        m_owner = rr_choose(req, m_ptr);
        m_sel   = m_owner;
        m_busy  = 1;
        m_cnt   = 0;
      end
    end else begin
      stop_done = done;
      stop_req  = !req[m_owner];
      stop_max  = (m_cnt == MH - 1);
      m_to = 0;
      if (stop_done || stop_req || stop_max) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 4;
        m_to   = stop_max && !stop_done && !stop_req;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic d, input logic rs, input string tag);
    logic [3:0] exp_gnt;
    @(negedge clk);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    exp_gnt = m_busy ? 4'(1 << m_owner) : 4'b0000;
    chk({tag, ".gnt"},       32'(gnt),       32'(exp_gnt));
    chk({tag, ".sel"},       32'(sel),       32'(m_sel));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
    chk({tag, ".timeout"},   32'(timeout),   32'(m_to));
    chk({tag, ".onehot"},    32'($onehot0(gnt)), 32'(1));
  endtask

  initial begin
    logic [3:0] rr;
    // Reset values
    cyc(4'b0000, 1'b0, 1'b1, "rst0");
    cyc(4'b1111, 1'b1, 1'b1, "rst1");
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.sel", 32'(sel), 32'h0);
    chk("rst.vld", 32'(gnt_valid), 32'h0);

    // Basic grant and release via done
    cyc(4'b1010, 1'b0, 1'b0, "b030a");
    chk("b030.gnt", 32'(gnt), 32'h2);
    chk("b030.sel", 32'(sel), 32'h1);
    cyc(4'b1010, 1'b1, 1'b0, "b030b");
    chk("b030.rel", 32'(gnt), 32'h0);
    cyc(4'b1010, 1'b0, 1'b0, "b030c");
    chk("b030.ptr2", 32'(sel), 32'h3);

    // Round-robin order with done every grant
    cyc(4'b0000, 1'b0, 1'b1, "rst2");
    order_q.delete();
    for (int i = 0; i < 9; i++) begin
      cyc(4'b1111, 1'b1, 1'b0, "b031");
      if (gnt_valid) order_q.push_back(int'(sel));
      chk("b031.alt", 32'(gnt_valid), 32'((i % 2) == 0));
    end
    chk("b031.count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < order_q.size() && i < 5; i++)
      chk("b031.order", 32'(order_q[i]), 32'(i % 4));

    // Hold-time release with timeout
    cyc(4'b0000, 1'b0, 1'b1, "rst3");
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0100, 1'b0, 1'b0, "b032");
      if (gnt == 4'b0100) hits++;
      chk("b032.noto", 32'(timeout), 32'h0);
    end
    cyc(4'b0100, 1'b0, 1'b0, "b032r");
    chk("b032.hits", 32'(hits), 32'd4);
    chk("b032.to", 32'(timeout), 32'h1);
    chk("b032.gnt0", 32'(gnt), 32'h0);
    cyc(4'b1100, 1'b0, 1'b0, "b032n");
    chk("b032.ptr3", 32'(gnt), 32'h8);
    cyc(4'b0000, 1'b0, 1'b0, "b032e");
    chk("b032.toclr", 32'(timeout), 32'h0);

    // done coincident with hold limit on channel 3
    cyc(4'b0000, 1'b0, 1'b1, "rst4");
    cyc(4'b1000, 1'b0, 1'b0, "b033g");
    for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b0, 1'b0, "b033h");
    cyc(4'b1000, 1'b1, 1'b0, "b033r");
    chk("b033.to", 32'(timeout), 32'h0);
    chk("b033.gnt", 32'(gnt), 32'h0);
    cyc(4'b1001, 1'b0, 1'b0, "b033w");
    chk("b033.wrap", 32'(gnt), 32'h1);

    // Owner request drops mid-grant
    cyc(4'b0000, 1'b0, 1'b1, "rst5");
    cyc(4'b0001, 1'b0, 1'b0, "b034g");
    cyc(4'b0110, 1'b0, 1'b0, "b034d");
    chk("b034.drop", 32'(gnt), 32'h0);
    cyc(4'b0110, 1'b0, 1'b0, "b034n");
    chk("b034.next", 32'(gnt), 32'h2);

    // Reset mid-grant
    cyc(4'b0000, 1'b0, 1'b1, "rst6");
    cyc(4'b0010, 1'b0, 1'b0, "b035a");
    cyc(4'b0010, 1'b0, 1'b0, "b035b");
    cyc(4'b1000, 1'b0, 1'b0, "b035c");
    cyc(4'b1000, 1'b0, 1'b0, "b035d");
    cyc(4'b1000, 1'b0, 1'b1, "b035r");
    chk("b035.gnt", 32'(gnt), 32'h0);
    chk("b035.vld", 32'(gnt_valid), 32'h0);
    chk("b035.to", 32'(timeout), 32'h0);
    chk("b035.sel", 32'(sel), 32'h0);
    cyc(4'b1000, 1'b0, 1'b0, "b035g");
    chk("b035.gnt3", 32'(gnt), 32'h8);

    // Randomized traffic with sticky requests
    rr = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
      cyc(rr, ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
